ofmap_ctrl: RTL and testbench
=============================

OFMAP_CTRL -- requirements
Module: ofmap_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4096, meaning the number of 32-bit words in the ofmap SRAM.
REQ-002 The block SHALL have parameter LANES, default 8, meaning the number of words in one write-back beat.
REQ-003 CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 RSTn  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse that begins a layer.
REQ-006 out_words  input  13  number of words in the layer; sampled only on an accepted start.
REQ-007 wb_valid / wb_ready  input / output  1 / 1  write-back handshake from the PE array.
REQ-008 wb_data  input  32 x LANES  write-back beat payload.
REQ-009 drain_valid / drain_ready  output / input  1 / 1  drain stream handshake toward DMA.
REQ-010 drain_data  output  32  drain word.
REQ-011 sram_addr, sram_en, sram_we  output  12, 1, 1  SRAM port controls.
REQ-012 sram_di  output  32 x LANES  SRAM write data.
REQ-013 sram_do  input  32  SRAM read data; valid one cycle after sram_en; held while sram_en=0.
REQ-014 busy / done  output / output  1 / 1  busy is high outside IDLE; done is a one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have the states IDLE, FILL, PRIME and DRAIN.
REQ-016 In IDLE, a start pulse SHALL latch len and reset wr_ptr and rd_ptr to 0.
- len = min(out_words rounded down to a multiple of 8, DEPTH).
- If len=0: done pulses on the next cycle and the FSM stays in IDLE.
- If len>0: the FSM enters FILL.
REQ-017 start SHALL be ignored outside IDLE.
REQ-018 In FILL, wb_ready SHALL be 1.
- Each beat with wb_valid&wb_ready drives, in the same cycle: sram_we=1, sram_addr=wr_ptr[11:0], sram_di=wb_data.
- wr_ptr then advances by LANES.
REQ-019 The handshake in which wr_ptr+LANES==len SHALL move the FSM to PRIME.
REQ-020 In PRIME, the block SHALL drive sram_en=1 and sram_addr=0, set rd_ptr=1, and enter DRAIN on the next cycle.
REQ-021 In DRAIN, the block SHALL drive drain_valid=1 and drain_data=sram_do combinationally.
- drain_data stays stable while drain_ready=0, because sram_en is held at 0.
REQ-022 On a drain handshake with rd_ptr<len, the block SHALL drive sram_en=1 and sram_addr=rd_ptr[11:0] in the same cycle and increment rd_ptr.
- This gives one word per cycle of sustained throughput.
REQ-023 On a drain handshake with rd_ptr==len, the block SHALL pulse done on the next cycle and return to IDLE.
- The first drain word follows the last write-back beat by exactly 2 cycles.
REQ-024 sram_we and sram_en SHALL never be high in the same cycle.
REQ-025 wb_ready SHALL be 0 outside FILL, drain_valid SHALL be 0 outside DRAIN, and sram_we/sram_en SHALL be 0 when not specified above.
REQ-026 wr_ptr and rd_ptr SHALL be 13 bits wide, so a layer of len=DEPTH completes without wrap-around; sram_addr SHALL be the low 12 bits.

Reset
REQ-027 RSTn low SHALL, asynchronously, force state=IDLE and clear wr_ptr, rd_ptr, len and done.
- All outputs then read 0: busy, wb_ready, drain_valid, sram_en, sram_we, sram_addr.
REQ-028 A reset assertion mid-layer SHALL abandon the layer with no done pulse; the first post-reset start SHALL begin cleanly.

Structure
REQ-029 The state enum and the constants DEPTH, LANES and AW=12 SHALL live in a shared package ofmap_pkg.
REQ-030 The block SHALL be a single module with no sub-module.
- It connects directly to the existing ofmap SRAM's CLK/ADDR/EN/WE/DI/DO ports.

Verification
REQ-031 Stimulus: start with out_words=16; two back-to-back wb beats; drain_ready=1. Required response: SRAM writes at addresses 0 and 8; drain emits 16 words in order on consecutive cycles starting 2 cycles after the last beat; one done pulse.
REQ-032 Stimulus: drain_ready toggled randomly during a 32-word drain. Required response: no word is lost or duplicated, and drain_data is stable while drain_valid&!drain_ready.
REQ-033 Stimulus: out_words=0, then out_words=13. Required response: for 0, done pulses the next cycle with no SRAM access; for 13, the layer is treated as 8 words (one beat, 8 drained words).
REQ-034 Stimulus: out_words=5000. Required response: 512 beats fill the SRAM; 4096 words drain, the last at address 4095; no wrap-around.
REQ-035 Stimulus: RSTn pulsed low mid-DRAIN, then a new 8-word layer. Required response: outputs go to 0 immediately; no done pulse for the abandoned layer; the new layer completes normally.
REQ-036 Stimulus: start pulsed during FILL. Required response: the pulse is ignored, and len/pointers are unchanged.

Source files
------------

// File: rtl/ofmap_pkg.sv
// Shared constants and FSM state encoding for the ofmap SRAM controller.
// Pointer width PW covers 0..DEPTH inclusive so a full-depth layer never wraps.
package ofmap_pkg;

    localparam int DEPTH = 4096;
    localparam int LANES = 8;
    localparam int AW    = 12;
    localparam int PW    = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        PRIME = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/ofmap_ctrl.sv
// Ofmap buffer controller: fills SRAM from PE write-back beats, then drains it word by word to DMA.
// Latency: first drain word 2 cycles after the last write-back beat, then 1 word/cycle.
// Backpressure: wb_ready only in FILL; drain stalls hold SRAM idle so drain_data stays stable.
module ofmap_ctrl
    import ofmap_pkg::*;
#(
    parameter int DEPTH = ofmap_pkg::DEPTH,
    parameter int LANES = ofmap_pkg::LANES
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  start,
    input  logic [PW-1:0]         out_words,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [32*LANES-1:0]   wb_data,
    output logic                  drain_valid,
    input  logic                  drain_ready,
    output logic [31:0]           drain_data,
    output logic [AW-1:0]         sram_addr,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [32*LANES-1:0]   sram_di,
    input  logic [31:0]           sram_do,
    output logic                  busy,
    output logic                  done
);

    localparam logic [PW-1:0] LANES_P  = PW'(LANES);
    localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
    localparam logic [PW-1:0] RND_MASK = ~PW'(7);

    state_t          state, state_nxt;
    logic [PW-1:0]   wr_ptr, wr_ptr_nxt;
    logic [PW-1:0]   rd_ptr, rd_ptr_nxt;
    logic [PW-1:0]   len, len_nxt;
    logic            done_nxt;
    logic [PW-1:0]   words_rnd;
    logic [PW-1:0]   start_len;
    logic [PW-1:0]   wr_ptr_inc;

    assign words_rnd  = out_words & RND_MASK;
    assign start_len  = (words_rnd > DEPTH_P) ? DEPTH_P : words_rnd;
    assign wr_ptr_inc = wr_ptr + LANES_P;
    assign sram_di    = wb_data;
    assign busy       = (state != IDLE);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            len    <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            len    <= len_nxt;
            done   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        wr_ptr_nxt  = wr_ptr;
        rd_ptr_nxt  = rd_ptr;
        len_nxt     = len;
        done_nxt    = 1'b0;
        wb_ready    = 1'b0;
        drain_valid = 1'b0;
        drain_data  = '0;
        sram_en     = 1'b0;
        sram_we     = 1'b0;
        sram_addr   = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    len_nxt    = start_len;
                    wr_ptr_nxt = '0;
                    rd_ptr_nxt = '0;
                    if (start_len == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = FILL;
                    end
                end
            end

            FILL: begin
                wb_ready = 1'b1;
                if (wb_valid) begin
                    sram_we    = 1'b1;
                    sram_addr  = wr_ptr[AW-1:0];
                    wr_ptr_nxt = wr_ptr_inc;
                    if (wr_ptr_inc == len) begin
                        state_nxt = PRIME;
                    end
                end
            end

            // Pre-fetch word 0 so DRAIN starts with valid read data.
            PRIME: begin
                sram_en    = 1'b1;
                sram_addr  = '0;
                rd_ptr_nxt = PW'(1);
                state_nxt  = DRAIN;
            end

            DRAIN: begin
                drain_valid = 1'b1;
                drain_data  = sram_do;
                if (drain_ready) begin
                    if (rd_ptr < len) begin
                        sram_en    = 1'b1;
                        sram_addr  = rd_ptr[AW-1:0];
                        rd_ptr_nxt = rd_ptr + PW'(1);
                    end else begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ofmap_ctrl.sv
// Directed bench for ofmap_ctrl with a behavioural wide-write / single-word-read SRAM.
module tb_ofmap_ctrl;

    localparam int LANES = 8;

    logic                  CLK = 1'b0;
    logic                  RSTn = 1'b0;
    logic                  start = 1'b0;
    logic [12:0]           out_words = '0;
    logic                  wb_valid = 1'b0;
    logic                  wb_ready;
    logic [32*LANES-1:0]   wb_data = '0;
    logic                  drain_valid;
    logic                  drain_ready = 1'b1;
    logic [31:0]           drain_data;
    logic [11:0]           sram_addr;
    logic                  sram_en;
    logic                  sram_we;
    logic [32*LANES-1:0]   sram_di;
    logic [31:0]           sram_do = '0;
    logic                  busy;
    logic                  done;

    ofmap_ctrl #(.DEPTH(4096), .LANES(LANES)) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .start       (start),
        .out_words   (out_words),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_data     (wb_data),
        .drain_valid (drain_valid),
        .drain_ready (drain_ready),
        .drain_data  (drain_data),
        .sram_addr   (sram_addr),
        .sram_en     (sram_en),
        .sram_we     (sram_we),
        .sram_di     (sram_di),
        .sram_do     (sram_do),
        .busy        (busy),
        .done        (done)
    );

    always #5 CLK = ~CLK;

    logic [31:0] mem [4096];

    always @(posedge CLK) begin
        if (sram_we)
            for (int l = 0; l < LANES; l++)
                mem[int'(sram_addr) + l] <= sram_di[32*l +: 32];
        if (sram_en)
            sram_do <= mem[sram_addr];
    end

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          wr_addrs[$];
    logic [31:0] got[$];
    int          first_drain, last_drain, last_beat;
    int          done_cnt, ovl_cnt, acc_cnt, unstable, stalls, last_rd_addr;
    logic        held_vld = 1'b0;
    logic [31:0] held = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (wb_valid && wb_ready) begin
            wr_addrs.push_back(int'(sram_addr));
            last_beat = cyc;
        end
        if (sram_we || sram_en) acc_cnt++;
        if (sram_en) last_rd_addr = int'(sram_addr);
        if (sram_we && sram_en) ovl_cnt++;
        if (done) done_cnt++;
        if (held_vld && drain_valid && drain_data !== held) unstable++;
        held_vld = drain_valid && !drain_ready;
        held     = drain_data;
        if (held_vld) stalls++;
        if (drain_valid && drain_ready) begin
            if (got.size() == 0) first_drain = cyc;
            last_drain = cyc;
            got.push_back(drain_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got_v, exp_v);
        end
    endtask

    function automatic logic [31:0] pat(input int tid, input int idx);
        return {tid[7:0], 8'h5a, idx[15:0]};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_logs();
        wr_addrs.delete();
        got.delete();
        done_cnt = 0; ovl_cnt = 0; acc_cnt = 0; unstable = 0; stalls = 0;
        first_drain = -1; last_drain = -1; last_beat = -1; last_rd_addr = -1;
    endtask

    task automatic do_start(input int n);
        out_words = 13'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_beats(input int tid, input int nb, input int from);
        int guard;
        for (int b = from; b < from + nb; b++) begin
            for (int l = 0; l < LANES; l++)
                wb_data[32*l +: 32] = pat(tid, b*LANES + l);
            wb_valid = 1'b1;
            guard = 0;
            while (!wb_ready && guard < 20) begin
                tick();
                guard++;
            end
            if (!wb_ready) begin
                chk("wb_ready_timeout", 32'd0, 32'd1);
                wb_valid = 1'b0;
                return;
            end
            tick();
        end
        wb_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rand_rdy);
        int d0, n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            drain_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        drain_ready = 1'b1;
        if (n >= budget) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_words(input string tag, input int tid, input int n);
        int errs;
        errs = 0;
        chk(tag, got.size(), n);
        for (int i = 0; i < n; i++)
            if (i >= got.size() || got[i] !== pat(tid, i)) errs++;
        chk("data_errs", errs, 0);
    endtask

    initial begin
        int n;
        clear_logs();
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_wb_ready", wb_ready, 0);
        chk("rst_drain_valid", drain_valid, 0);
        chk("rst_sram_en", sram_en, 0);
        chk("rst_sram_we", sram_we, 0);
        chk("rst_sram_addr", sram_addr, 0);
        chk("rst_done", done, 0);
        @(posedge CLK); #1;
        RSTn = 1'b1;
        tick();

        // 16-word layer, two back-to-back beats, free-running drain
        clear_logs();
        do_start(16);
        chk("t1_busy", busy, 1);
        send_beats(1, 2, 0);
        wait_done(100, 1'b0);
        chk("t1_nbeats", wr_addrs.size(), 2);
        chk("t1_addr0", wr_addrs.size() > 0 ? wr_addrs[0] : -1, 0);
        chk("t1_addr1", wr_addrs.size() > 1 ? wr_addrs[1] : -1, 8);
        check_words("t1_nwords", 1, 16);
        chk("t1_first_lat", first_drain - last_beat, 2);
        chk("t1_consec", last_drain - first_drain, 15);
        chk("t1_done_cnt", done_cnt, 1);
        tick();
        chk("t1_idle", busy, 0);

        // 32-word layer with random drain backpressure
        clear_logs();
        do_start(32);
        send_beats(2, 4, 0);
        wait_done(400, 1'b1);
        check_words("t2_nwords", 2, 32);
        chk("t2_stable", unstable, 0);
        chk("t2_stalls_seen", stalls != 0, 1);
        chk("t2_done_cnt", done_cnt, 1);

        // zero-length layer
        tick();
        clear_logs();
        out_words = 13'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_done_next", done, 1);
        chk("t3_busy", busy, 0);
        tick();
        chk("t3_done_clr", done, 0);
        tick();
        chk("t3_no_access", acc_cnt, 0);
        chk("t3_done_cnt", done_cnt, 1);

        // 13 words rounds down to one beat
        clear_logs();
        do_start(13);
        send_beats(3, 1, 0);
        wait_done(100, 1'b0);
        chk("t3b_nbeats", wr_addrs.size(), 1);
        check_words("t3b_nwords", 3, 8);
        chk("t3b_done_cnt", done_cnt, 1);

        // oversize layer clamps to full depth
        tick();
        clear_logs();
        do_start(5000);
        send_beats(4, 512, 0);
        wait_done(6000, 1'b0);
        chk("t4_nbeats", wr_addrs.size(), 512);
        chk("t4_last_wr", wr_addrs.size() == 512 ? wr_addrs[511] : -1, 4088);
        check_words("t4_nwords", 4, 4096);
        chk("t4_last_rd", last_rd_addr, 4095);
        chk("t4_done_cnt", done_cnt, 1);

        // reset mid-drain, then a fresh 8-word layer
        tick();
        clear_logs();
        do_start(16);
        send_beats(5, 2, 0);
        n = 0;
        while (got.size() < 5 && n < 50) begin
            tick();
            n++;
        end
        chk("t5_in_drain", drain_valid, 1);
        RSTn = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_drain_valid", drain_valid, 0);
        chk("t5_sram_en", sram_en, 0);
        chk("t5_sram_addr", sram_addr, 0);
        tick(); tick(); tick();
        chk("t5_no_done", done_cnt, 0);
        RSTn = 1'b1;
        tick();
        clear_logs();
        do_start(8);
        send_beats(6, 1, 0);
        wait_done(100, 1'b0);
        check_words("t5_nwords", 6, 8);
        chk("t5_done_cnt", done_cnt, 1);

        // start during FILL is ignored
        tick();
        clear_logs();
        do_start(16);
        send_beats(7, 1, 0);
        out_words = 13'd64;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_wb_ready", wb_ready, 1);
        tick();
        send_beats(7, 1, 1);
        wait_done(100, 1'b0);
        chk("t6_nbeats", wr_addrs.size(), 2);
        chk("t6_addr1", wr_addrs.size() > 1 ? wr_addrs[1] : -1, 8);
        check_words("t6_nwords", 7, 16);
        chk("t6_done_cnt", done_cnt, 1);

        chk("we_en_overlap", ovl_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
